// File: rtl/sdio_spi_master_if.sv
// 68SEC000 register-cycle bus between the SDIO Z2 decoder and the SD SPI master.
interface sdio_spi_master_if;
    logic       SDIO_SEL;
    logic       AS_n;
    logic       DS_n;
    logic       RW_n;
    logic [1:0] A;
    logic [7:0] D_IN;
    logic [7:0] D_OUT;
    logic       D_OE;
    logic       DTACK_n;

    modport master (output SDIO_SEL, AS_n, DS_n, RW_n, A, D_IN,
                    input  D_OUT, D_OE, DTACK_n);
    modport slave  (input  SDIO_SEL, AS_n, DS_n, RW_n, A, D_IN,
                    output D_OUT, D_OE, DTACK_n);
endinterface

// File: rtl/sdio_spi_master.sv
// SD card SPI master (mode 0) behind the SDIO Z2 decoder; bus and SPI FSMs both run on C100M.
// Define SDIO_AUTOREAD_EN to enable CONTROL.autoread streaming DATA reads.
module sdio_spi_master #(
    parameter int SLOW_DIV    = 125,
    parameter int FAST_DIV    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             C100M,
    input  logic             RESET,
    sdio_spi_master_if.slave cpu,
    output logic             SD_CS_n,
    output logic             SD_SCK,
    output logic             SD_MOSI,
    input  logic             SD_MISO,
    input  logic             SD_CD_n
);
`ifdef SDIO_AUTOREAD_EN
    localparam logic AUTOREAD = 1'b1;
`else
    localparam logic AUTOREAD = 1'b0;
`endif
    localparam logic [7:0] SLOW_HD = 8'(SLOW_DIV);
    localparam logic [7:0] FAST_HD = 8'(FAST_DIV);

    localparam logic [1:0] B_IDLE   = 2'd0;
    localparam logic [1:0] B_DECODE = 2'd1;
    localparam logic [1:0] B_ACK    = 2'd2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] R_DATA    = 2'd0;
    localparam logic [1:0] R_STATUS  = 2'd1;
    localparam logic [1:0] R_CONTROL = 2'd2;

    logic [SYNC_STAGES-1:0] as_sync, ds_sync, sel_sync, miso_sync, cd_sync;
    logic as_s, ds_s, sel_s, miso_s, cd_s;

    logic [1:0] bstate, sstate;
    logic       armed;
    logic       dtack_n, d_oe;
    logic [7:0] d_out;
    logic       cs, fast, autord;
    logic [7:0] div_reg;

    logic       busy, sck, mosi, samp, rx_valid;
    logic [7:0] rx, sh, cnt, hdiv;
    logic [3:0] tog;

    logic       spi_done, busy_eff, dec_go, start, rx_clr;
    logic [7:0] rd_data, start_byte, eff_div, rx_post;

    // AS chain resets to "asserted" so a strobe held across reset must go high before it counts.
    always_ff @(posedge C100M) begin
        if (RESET) begin
            as_sync   <= '0;
            ds_sync   <= '1;
            sel_sync  <= '0;
            miso_sync <= '1;
            cd_sync   <= '1;
        end else begin
            as_sync   <= {as_sync[SYNC_STAGES-2:0], cpu.AS_n};
            ds_sync   <= {ds_sync[SYNC_STAGES-2:0], cpu.DS_n};
            sel_sync  <= {sel_sync[SYNC_STAGES-2:0], cpu.SDIO_SEL};
            miso_sync <= {miso_sync[SYNC_STAGES-2:0], SD_MISO};
            cd_sync   <= {cd_sync[SYNC_STAGES-2:0], SD_CD_n};
        end
    end

    assign as_s   = as_sync[SYNC_STAGES-1];
    assign ds_s   = ds_sync[SYNC_STAGES-1];
    assign sel_s  = sel_sync[SYNC_STAGES-1];
    assign miso_s = miso_sync[SYNC_STAGES-1];
    assign cd_s   = cd_sync[SYNC_STAGES-1];

    // A byte finishing this cycle frees the shifter for a waiting DATA access.
    assign spi_done   = (sstate == S_DONE);
    assign busy_eff   = busy & ~spi_done;
    assign dec_go     = (bstate == B_DECODE) && !((cpu.A == R_DATA) && busy_eff);
    assign rx_clr     = dec_go && cpu.RW_n && (cpu.A == R_DATA);
    assign start      = dec_go && (cpu.A == R_DATA) && (!cpu.RW_n || autord);
    assign start_byte = cpu.RW_n ? 8'hFF : cpu.D_IN;
    assign eff_div    = fast ? FAST_HD : div_reg;
    assign rx_post    = spi_done ? sh : rx;

    always_comb begin
        rd_data = div_reg;
        case (cpu.A)
            R_DATA:    rd_data = rx_post;
            R_STATUS:  rd_data = {5'b0, rx_valid | spi_done, ~cd_s, busy_eff};
            R_CONTROL: rd_data = {5'b0, autord, fast, cs};
            default:   rd_data = div_reg;
        endcase
    end

    always_ff @(posedge C100M) begin
        if (RESET) begin
            bstate  <= B_IDLE;
            armed   <= 1'b0;
            dtack_n <= 1'b1;
            d_oe    <= 1'b0;
            d_out   <= 8'h00;
            cs      <= 1'b0;
            fast    <= 1'b0;
            autord  <= 1'b0;
            div_reg <= SLOW_HD;
        end else begin
            case (bstate)
                B_IDLE: begin
                    if (as_s) armed <= 1'b1;
                    if (armed && sel_s && !as_s && !ds_s) begin
                        bstate <= B_DECODE;
                        armed  <= 1'b0;
                    end
                end
                B_DECODE: if (dec_go) begin
                    bstate <= B_ACK;
                    d_oe   <= cpu.RW_n;
                    if (cpu.RW_n) d_out <= rd_data;
                    else if (cpu.A == R_CONTROL) begin
                        cs     <= cpu.D_IN[0];
                        fast   <= cpu.D_IN[1];
                        autord <= cpu.D_IN[2] & AUTOREAD;
                    end else if (cpu.A == 2'd3)
                        div_reg <= (cpu.D_IN == 8'd0) ? 8'd1 : cpu.D_IN;
                end
                B_ACK: begin
                    // D_OUT/D_OE were set a cycle ago; DTACK follows.
                    if (as_s) begin
                        bstate  <= B_IDLE;
                        dtack_n <= 1'b1;
                        d_oe    <= 1'b0;
                    end else
                        dtack_n <= 1'b0;
                end
                default: bstate <= B_IDLE;
            endcase
        end
    end

    always_ff @(posedge C100M) begin
        if (RESET) begin
            sstate   <= S_IDLE;
            busy     <= 1'b0;
            sck      <= 1'b0;
            mosi     <= 1'b1;
            samp     <= 1'b0;
            rx       <= 8'hFF;
            rx_valid <= 1'b0;
            sh       <= 8'hFF;
            cnt      <= SLOW_HD;
            hdiv     <= SLOW_HD;
            tog      <= 4'd0;
        end else begin
            if (rx_clr) rx_valid <= 1'b0;
            case (sstate)
                S_SHIFT: begin
                    if (cnt == 8'd1) begin
                        cnt <= hdiv;
                        sck <= ~sck;
                        tog <= tog + 4'd1;
                        if (!sck) samp <= miso_s;
                        else begin
                            sh   <= {sh[6:0], samp};
                            mosi <= (tog == 4'd15) ? 1'b1 : sh[6];
                        end
                        if (tog == 4'd15) sstate <= S_DONE;
                    end else
                        cnt <= cnt - 8'd1;
                end
                S_DONE: begin
                    rx     <= sh;
                    busy   <= 1'b0;
                    mosi   <= 1'b1;
                    sstate <= S_IDLE;
                    if (!rx_clr) rx_valid <= 1'b1;
                end
                default: ;
            endcase
            // Divider is captured here, so register writes mid-byte wait for the next byte.
            if (start) begin
                sstate <= S_SHIFT;
                busy   <= 1'b1;
                sh     <= start_byte;
                mosi   <= start_byte[7];
                cnt    <= eff_div;
                hdiv   <= eff_div;
                tog    <= 4'd0;
                sck    <= 1'b0;
            end
        end
    end

    assign cpu.DTACK_n = dtack_n;
    assign cpu.D_OE    = d_oe;
    assign cpu.D_OUT   = d_out;
    assign SD_CS_n     = ~cs;
    assign SD_SCK      = sck;
    assign SD_MOSI     = mosi;

endmodule

// File: tb/tb_sdio_spi_master.sv
// Randomised register-level bench for sdio_spi_master with a byte-level SPI reference model.
module tb_sdio_spi_master;
  logic C100M = 1'b0;
  logic RESET = 1'b1;
  logic SD_CS_n, SD_SCK, SD_MOSI, SD_MISO;
  logic SD_CD_n = 1'b0;

  sdio_spi_master_if bus();

  sdio_spi_master #(.SLOW_DIV(125), .FAST_DIV(2), .SYNC_STAGES(2)) dut (
    .C100M(C100M), .RESET(RESET), .cpu(bus),
    .SD_CS_n(SD_CS_n), .SD_SCK(SD_SCK), .SD_MOSI(SD_MOSI),
    .SD_MISO(SD_MISO), .SD_CD_n(SD_CD_n)
  );

  always #5 C100M = ~C100M;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge C100M) cyc <= cyc + 1;

  // SCK edge recorder, sampled mid-cycle
  int rise_q[$];
  int fall_q[$];
  logic mosi_q[$];
  logic sck_q = 1'b0;
  always @(negedge C100M) begin
    if (SD_SCK && !sck_q) begin rise_q.push_back(cyc); mosi_q.push_back(SD_MOSI); end
    if (!SD_SCK && sck_q) fall_q.push_back(cyc);
    sck_q = SD_SCK;
  end

  // Card model: presents the next pattern bit after every falling SCK, or loops MOSI back
  int nfall = 0;
  int miso_base = 0;
  logic loopback = 1'b0;
  logic [7:0] miso_byte = 8'hFF;
  logic [2:0] mi;
  always @(negedge SD_SCK) nfall <= nfall + 1;
  assign mi = 3'(nfall - miso_base);
  assign SD_MISO = loopback ? SD_MOSI : miso_byte[~mi];

  // reference register state
  bit m_fast = 0;
  bit m_cs = 0;
  int m_div = 125;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_cyc(input bit rd, input logic [1:0] a, input logic [7:0] wd,
                         output logic [7:0] rdat, output int t_ack);
    int n;
    logic oe_q;
    logic [7:0] do_q;
    @(negedge C100M);
    bus.RW_n = rd; bus.A = a; bus.D_IN = wd;
    bus.SDIO_SEL = 1'b1; bus.AS_n = 1'b0; bus.DS_n = 1'b0;
    n = 0; oe_q = 1'b0; do_q = 8'h00;
    while (bus.DTACK_n && n < 5000) begin
      oe_q = bus.D_OE; do_q = bus.D_OUT;
      @(negedge C100M); n++;
    end
    chk("dtack", bus.DTACK_n, 0);
    t_ack = cyc;
    rdat = do_q;
    if (rd) chk("oe_early", oe_q, 1);
    else    chk("oe_wr", bus.D_OE, 0);
    bus.AS_n = 1'b1; bus.DS_n = 1'b1; bus.SDIO_SEL = 1'b0;
    n = 0;
    while (!bus.DTACK_n && n < 20) begin @(negedge C100M); n++; end
    chk("release", {bus.DTACK_n, bus.D_OE}, 2'b10);
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d, output int t);
    logic [7:0] unused_rd;
    bus_cyc(1'b0, a, d, unused_rd, t);
  endtask

  task automatic cpu_rd(input logic [1:0] a, output logic [7:0] d);
    int t;
    bus_cyc(1'b1, a, 8'h00, d, t);
  endtask

  task automatic wait_idle(output logic [7:0] st, output bit first_busy);
    int n;
    n = 0; first_busy = 0;
    do begin
      cpu_rd(2'd1, st);
      if (n == 0) first_busy = st[0];
      n++;
    end while (st[0] && n < 400);
    chk("idle", st[0], 0);
  endtask

  function automatic int half_div();
    return m_fast ? 2 : ((m_div == 0) ? 1 : m_div);
  endfunction

  // One byte: write DATA, optional DIVIDER write mid-byte, wait, check SCK/MOSI/rx/status.
  task automatic xfer(input logic [7:0] tx, input logic [7:0] mb, input bit rx_chk, input int mid_div);
    int hd, t, b, nr, dummy;
    logic [7:0] st, r, mo;
    bit fb;
    hd = half_div();
    miso_byte = mb; miso_base = nfall; b = rise_q.size();
    cpu_wr(2'd0, tx, t);
    if (mid_div >= 0) begin cpu_wr(2'd3, mid_div[7:0], dummy); m_div = mid_div; end
    wait_idle(st, fb);
    chk("busy_set", fb, 1);
    chk("st_done", st, {5'b0, 1'b1, ~SD_CD_n, 1'b0});
    nr = rise_q.size() - b;
    chk("n_rise", nr, 8);
    if (nr == 8) begin
      chk("lat_first", rise_q[b] - t, hd - 1);
      for (int k = 1; k < 8; k++) chk("sck_per", rise_q[b+k] - rise_q[b+k-1], 2 * hd);
      mo = 8'h00;
      for (int k = 0; k < 8; k++) mo = {mo[6:0], mosi_q[b+k]};
      chk("mosi", mo, tx);
    end
    chk("mosi_idle", SD_MOSI, 1);
    cpu_rd(2'd0, r);
    if (rx_chk) chk("rx", r, loopback ? tx : mb);
    cpu_rd(2'd1, st);
    chk("st_clr", st, {6'b0, ~SD_CD_n, 1'b0});
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t1, t2, b, bf, nr, cnt;
    logic [7:0] r, st;
    bit fb;
    bus.SDIO_SEL = 1'b0; bus.AS_n = 1'b1; bus.DS_n = 1'b1;
    bus.RW_n = 1'b1; bus.A = 2'd0; bus.D_IN = 8'h00;
    repeat (4) @(negedge C100M);
    RESET = 1'b0;
    @(negedge C100M);
    chk("rst_pins", {SD_CS_n, SD_SCK, SD_MOSI, bus.DTACK_n, bus.D_OE}, 5'b10110);
    chk("rst_dout", bus.D_OUT, 0);
    cpu_rd(2'd1, r); chk("rst_status", r, 8'h02);
    cpu_rd(2'd2, r); chk("rst_ctl", r, 8'h00);
    cpu_rd(2'd3, r); chk("rst_div", r, 125);

    // slow loopback byte
    cpu_wr(2'd2, 8'h01, t1); m_cs = 1;
    chk("cs_on", SD_CS_n, 0);
    loopback = 1'b1;
    xfer(8'hA5, 8'h00, 1, -1);
    loopback = 1'b0;

    // back-to-back fast writes
    cpu_wr(2'd2, 8'h03, t1); m_fast = 1;
    b = rise_q.size(); bf = fall_q.size();
    cpu_wr(2'd0, 8'h5A, t1);
    cpu_wr(2'd0, 8'hC3, t2);
    wait_idle(st, fb);
    nr = rise_q.size() - b;
    chk("b2b_rises", nr, 16);
    if (nr == 16 && fall_q.size() - bf >= 16) begin
      chk("b2b_lat", rise_q[b] - t1, 1);
      chk("b2b_gap", t2 - fall_q[bf+7], 2);
      for (int k = 1; k < 16; k++) if (k != 8) chk("b2b_per", rise_q[b+k] - rise_q[b+k-1], 4);
      r = 8'h00;
      for (int k = 8; k < 16; k++) r = {r[6:0], mosi_q[b+k]};
      chk("b2b_mosi2", r, 8'hC3);
    end
    cpu_rd(2'd0, r);

    // DIVIDER=0 -> half-period 1
    cpu_wr(2'd2, 8'h01, t1); m_fast = 0;
    cpu_wr(2'd3, 8'h00, t1); m_div = 0;
    cpu_rd(2'd3, r); chk("div0_rd", r, 1);
    xfer(8'h3E, 8'h00, 0, -1);

    // divider change mid-byte
    cpu_wr(2'd3, 8'd6, t1); m_div = 6;
    xfer(8'h96, 8'h4B, 1, 3);
    xfer(8'h0F, 8'hE1, 1, -1);

    // random bytes
    for (int i = 0; i < 6; i++) begin
      bit f;
      int d;
      logic [7:0] tx, mb;
      f = ($urandom_range(0, 2) == 0);
      d = $urandom_range(3, 9);
      tx = 8'($urandom); mb = 8'($urandom);
      SD_CD_n = 1'($urandom_range(0, 1));
      cpu_wr(2'd2, {6'b0, f, 1'b1}, t1); m_fast = f;
      cpu_wr(2'd3, 8'(d), t1); m_div = d;
      cpu_rd(2'd2, r); chk("ctl_rd", r, {6'b0, f, 1'b1});
      xfer(tx, mb, !f, -1);
    end
    SD_CD_n = 1'b0;

    // reset at bit 4 with a DATA write held waiting on busy
    cpu_wr(2'd2, 8'h01, t1); m_fast = 0;
    cpu_wr(2'd3, 8'd10, t1); m_div = 10;
    b = rise_q.size();
    cpu_wr(2'd0, 8'hF0, t1);
    cnt = 0;
    while (rise_q.size() - b < 4 && cnt < 500) begin @(negedge C100M); cnt++; end
    chk("bit4_reached", rise_q.size() - b, 4);
    bus.RW_n = 1'b0; bus.A = 2'd0; bus.D_IN = 8'h11;
    bus.SDIO_SEL = 1'b1; bus.AS_n = 1'b0; bus.DS_n = 1'b0;
    repeat (6) @(negedge C100M);
    chk("wait_state", bus.DTACK_n, 1);
    RESET = 1'b1;
    @(negedge C100M);
    chk("rst_mid", {SD_SCK, SD_CS_n, SD_MOSI}, 3'b011);
    RESET = 1'b0;
    m_cs = 0; m_fast = 0; m_div = 125;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin @(negedge C100M); if (!bus.DTACK_n) cnt++; end
    chk("no_ack_held", cnt, 0);
    bus.AS_n = 1'b1; bus.DS_n = 1'b1; bus.SDIO_SEL = 1'b0;
    repeat (4) @(negedge C100M);
    cpu_rd(2'd1, r); chk("rst_mid_status", r, 8'h02);
    cpu_rd(2'd3, r); chk("rst_mid_div", r, 125);

    // autoread
    cpu_wr(2'd3, 8'd4, t1); m_div = 4;
    cpu_wr(2'd2, 8'h05, t1); m_cs = 1;
    cpu_rd(2'd2, r);
`ifdef SDIO_AUTOREAD_EN
    chk("ar_ctl", r, 8'h05);
    miso_byte = 8'h3C; miso_base = nfall; b = rise_q.size();
    cpu_rd(2'd0, r);
    for (int k = 0; k < 2; k++) begin
      cpu_rd(2'd0, r); chk("ar_rx", r, 8'h3C);
      cpu_rd(2'd1, st); chk("ar_busy", st[0], 1);
    end
    wait_idle(st, fb);
    nr = rise_q.size() - b;
    chk("ar_rises", nr, 24);
    cnt = 0;
    for (int k = b; k < rise_q.size(); k++) if (!mosi_q[k]) cnt++;
    chk("ar_mosi_ff", cnt, 0);
    cpu_wr(2'd2, 8'h01, t1);
`else
    chk("ar_ctl", r, 8'h01);
    b = rise_q.size();
    cpu_rd(2'd0, r);
    repeat (60) @(negedge C100M);
    chk("ar_no_xfer", rise_q.size() - b, 0);
    cpu_rd(2'd1, r); chk("ar_status", r, 8'h02);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
